lsu_rmw_ctrl: RTL and testbench

Load/store initiator between the MEM pipeline stage and a word-organised data memory that supports whole-word writes only, with a request/grant/read-valid handshake. It accepts one byte, halfword or word access at a time and performs the memory accesses needed for it. Sub-word stores become a read-modify-write sequence. Sub-word loads are lane-extracted and sign- or zero-extended. Misaligned or illegal accesses are rejected with an error response and never reach memory.

---
 rtl/lsu_rmw_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lsu_rmw_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw_ctrl.sv
// Load/store initiator for a word-only data memory: sub-word stores become read-modify-write,
// sub-word loads are lane-extracted and extended, misaligned/illegal accesses are rejected.
module lsu_rmw_ctrl #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StResp} state_e;

   state_e              state_q, state_d;
   logic                we_q, sgn_q, err_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, word_q;
   logic                accept, req_err;
   logic [ADDR_W-1:0]   word_addr;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [DATA_W-1:0]   load_data, merge_data;

   assign req_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign accept    = req_valid & req_ready;
   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         2'b01:   req_err = req_addr[0];
         2'b10:   req_err = (req_addr[1:0] != 2'b00);
         2'b11:   req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (req_err)                state_d = StResp;
               else if (!req_we)           state_d = StRdReq;
               else if (req_size == 2'b10) state_d = StWrReq;
               else                        state_d = StRdReq;
            end
         end
         StRdReq:  if (mem_gnt) state_d = StRdWait;
         StRdWait: if (mem_rvalid) state_d = we_q ? StWrReq : StResp;
         StWrReq:  if (mem_gnt) state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            err_q   <= req_err;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state_q == StRdWait && mem_rvalid) begin
            word_q <= mem_rdata;
         end
      end
   end

   // Lane extraction of the captured word for loads
   always_comb begin
      byte_sel = 8'h00;
      unique case (addr_q[1:0])
         2'b00: byte_sel = word_q[7:0];
         2'b01: byte_sel = word_q[15:8];
         2'b10: byte_sel = word_q[23:16];
         2'b11: byte_sel = word_q[31:24];
      endcase
      half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
      case (size_q)
         2'b00:   load_data = {{24{sgn_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{sgn_q & half_sel[15]}}, half_sel};
         default: load_data = word_q;
      endcase
   end

   // Write word: captured word with only the addressed lane(s) replaced
   always_comb begin
      merge_data = word_q;
      case (size_q)
         2'b00: begin
            unique case (addr_q[1:0])
               2'b00: merge_data[7:0]   = wdata_q[7:0];
               2'b01: merge_data[15:8]  = wdata_q[7:0];
               2'b10: merge_data[23:16] = wdata_q[7:0];
               2'b11: merge_data[31:24] = wdata_q[7:0];
            endcase
         end
         2'b01: begin
            if (addr_q[1]) merge_data[31:16] = wdata_q[15:0];
            else           merge_data[15:0]  = wdata_q[15:0];
         end
         default: merge_data = wdata_q;
      endcase
   end

   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      unique case (state_q)
         StRdReq: begin
            mem_en   = 1'b1;
            mem_addr = word_addr;
         end
         StWrReq: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = word_addr;
            mem_wdata = merge_data;
         end
         StResp: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !we_q) resp_rdata = load_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Bench for lsu_rmw_ctrl: directed vector table, reset/stall corner cases, and random accesses
// against a shadow-memory reference model.
module tb_lsu_rmw_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_err, busy, mem_en, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   lsu_rmw_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check32(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Memory model: all decisions taken at the falling edge, handshakes seen at the next one
   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        prev_en = 1'b0, prev_we = 1'b0, prev_gnt = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0, rd_word = '0;
   int          rv_cnt = 0, rv_delay = 1, stall_cnt = 0, wr_cnt = 0;
   bit          rand_gnt = 1'b0, en_seen = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         rv_cnt     = 0;
         mem_rvalid = 1'b0;
         mem_gnt    = 1'b0;
         prev_en    = 1'b0;
         prev_gnt   = 1'b0;
      end else begin
         if (prev_en && prev_gnt) begin
            if (prev_we) begin
               mem[prev_addr[7:2]] = prev_wdata;
               wr_cnt++;
            end else begin
               rd_word = mem[prev_addr[7:2]];
               rv_cnt  = rv_delay;
            end
         end
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd_word;
            end
         end
         if (prev_en && !prev_gnt) begin
            check1("mem_hold_en", mem_en, 1'b1);
            check1("mem_hold_we", mem_we, prev_we);
            check32("mem_hold_addr", mem_addr, prev_addr);
            check32("mem_hold_wdata", mem_wdata, prev_wdata);
         end
         if (mem_en) begin
            en_seen = 1'b1;
            check1("busy_while_mem", busy, 1'b1);
            check1("ready_while_mem", req_ready, 1'b0);
            if (stall_cnt > 0) begin
               mem_gnt = 1'b0;
               stall_cnt--;
            end else begin
               mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
            end
         end else begin
            mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         prev_en    = mem_en;
         prev_we    = mem_we;
         prev_gnt   = mem_gnt;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
      end
   end

   task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      check1("idle_ready", req_ready, 1'b1);
      en_seen    = 1'b0;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      // Scramble the request bus so only latched values can produce the right result
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 60);
      check1("resp_seen", resp_valid, 1'b1);
      rdata = resp_rdata;
      err   = resp_err;
      @(negedge clk);
      check1("resp_one_cycle", resp_valid, 1'b0);
      check32("rdata_zero_idle", resp_rdata, 32'h0);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          stall;
      logic [31:0] exp_mem;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin
      logic [31:0] rd, w, v, mask, exp_rd;
      logic        er, exp_er, we, sgn;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      int          lat, sh, guard, wr_before;

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,
                   32'h0, 1'b0, 2, 0, 32'hDEADBEEF};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FF0000,
                   32'hFFFFFF80, 1'b0, 3, 0, 32'h80FF0000};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FF0000,
                   32'h00000080, 1'b0, 3, 0, 32'h80FF0000};
      vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, 32'hAAAABBBB,
                   32'h0, 1'b0, 4, 0, 32'h1234BBBB};
      vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h11111111,
                   32'h0, 1'b1, 1, 0, 32'h11111111};
      vecs[5]  = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h22222222,
                   32'h0, 1'b1, 1, 0, 32'h22222222};
      vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h18, 32'h01234567, 32'h0,
                   32'h0, 1'b0, 5, 3, 32'h01234567};
      vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h02, 32'h0, 32'h80017FFF,
                   32'hFFFF8001, 1'b0, 3, 0, 32'h80017FFF};
      vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h31, 32'hFFFFFFAB, 32'h11223344,
                   32'h0, 1'b0, 4, 0, 32'h1122AB44};
      vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h41, 32'h0000FFFF, 32'h33333333,
                   32'h0, 1'b1, 1, 0, 32'h33333333};
      vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h00, 32'h0, 32'h1234F00D,
                   32'h0000F00D, 1'b0, 3, 0, 32'h1234F00D};
      vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h08, 32'h0, 32'hFFFFFF7F,
                   32'h0000007F, 1'b0, 3, 0, 32'hFFFFFF7F};
      vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h4C, 32'hFFFFFFFF, 32'h44444444,
                   32'h0, 1'b1, 1, 0, 32'h44444444};

      // Reset state
      repeat (2) @(negedge clk);
      check1("rst_ready", req_ready, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_mem_en", mem_en, 1'b0);
      check1("rst_resp_valid", resp_valid, 1'b0);
      check32("rst_resp_rdata", resp_rdata, 32'h0);
      check32("rst_mem_addr", mem_addr, 32'h0);
      #2 rst = 1'b1;

      // Directed vectors
      for (int i = 0; i < NV; i++) begin
         for (int j = 0; j < 64; j++) mem[j] = {16'hC0DE, 8'(j), 8'(j)};
         mem[vecs[i].addr[7:2]] = vecs[i].init;
         stall_cnt = vecs[i].stall;
         rv_delay  = 1;
         do_access(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat);
         check32($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         check1($sformatf("v%0d_err", i), er, vecs[i].exp_err);
         check32($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check32($sformatf("v%0d_mem", i), mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
         check1($sformatf("v%0d_mem_en_seen", i), en_seen, ~vecs[i].exp_err);
      end

      // Reset while a byte store waits for read data
      mem[1]   = 32'h55667788;
      rv_delay = 6;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b00;
      req_addr  = 32'h5;
      req_wdata = 32'hEE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      guard = 0;
      while (rv_cnt == 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check1("rst_mid_in_rdwait", busy & ~mem_en, 1'b1);
      wr_before = wr_cnt;
      #2 rst = 1'b0;
      #1;
      check1("rst_mid_mem_en", mem_en, 1'b0);
      check1("rst_mid_busy", busy, 1'b0);
      check1("rst_mid_ready", req_ready, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check1("rst_mid_no_resp", resp_valid, 1'b0);
         check1("rst_mid_no_mem", mem_en, 1'b0);
      end
      check32("rst_mid_no_write", 32'(wr_cnt), 32'(wr_before));
      check32("rst_mid_mem_kept", mem[1], 32'h55667788);
      #2 rst = 1'b1;
      rv_delay = 1;
      mem[0]   = 32'h0BADF00D;
      do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
      check32("post_rst_load", rd, 32'h0BADF00D);
      check1("post_rst_err", er, 1'b0);
      check32("post_rst_latency", 32'(lat), 32'd3);

      // Random accesses with random grant stalls and read latency
      rand_gnt = 1'b1;
      for (int j = 0; j < 64; j++) begin
         mem[j]     = $urandom;
         ref_mem[j] = mem[j];
      end
      for (int n = 0; n < 150; n++) begin
         we       = 1'($urandom_range(0, 1));
         size     = 2'($urandom_range(0, 3));
         sgn      = 1'($urandom_range(0, 1));
         addr     = 32'($urandom_range(0, 63));
         wdata    = $urandom;
         rv_delay = $urandom_range(1, 3);
         exp_er   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00);
         exp_rd   = 32'h0;
         w        = ref_mem[addr[7:2]];
         sh       = 8 * int'(addr[1:0]);
         if (!exp_er) begin
            if (we) begin
               if (size == 2'b10) begin
                  ref_mem[addr[7:2]] = wdata;
               end else begin
                  mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
                  ref_mem[addr[7:2]] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
               end
            end else begin
               v = w >> sh;
               if (size == 2'b00)
                  exp_rd = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
               else if (size == 2'b01)
                  exp_rd = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
               else
                  exp_rd = w;
            end
         end
         do_access(we, size, sgn, addr, wdata, rd, er, lat);
         check32($sformatf("rnd%0d_rdata", n), rd, exp_rd);
         check1($sformatf("rnd%0d_err", n), er, exp_er);
      end
      rand_gnt = 1'b0;
      for (int j = 0; j < 16; j++) begin
         check32($sformatf("rnd_mem%0d", j), mem[j], ref_mem[j]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
